arm_multicycle_controller: RTL
==============================

ARM_MULTICYCLE_CONTROLLER -- requirements
Module: arm_multicycle_controller

Interface
REQ-001 SHALL have no parameters; control encodings SHALL be fixed by the shared package.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 Cond  input  4  Instr[31:28].
REQ-005 Op  input  2  Instr[27:26].
REQ-006 Funct  input  6  Instr[25:20].
REQ-007 Rd  input  4  Instr[15:12].
REQ-008 ALUFlags  input  4  {N,Z,C,V} from the datapath ALU, combinational in the current cycle.
REQ-009 PCWrite, IRWrite, RegWrite, MemWrite  output  1 each  write enables.
REQ-010 AdrSrc, ALUSrcA  output  1 each  address mux select (1=ALUOut); SrcA mux select (1=PC).
REQ-011 ALUSrcB, ResultSrc  output  2 each  SrcB select: 00=RD2, 01=ExtImm, 10=const 4; Result select: 00=ALUOut, 01=Data, 10=ALUResult.
REQ-012 ImmSrc, RegSrc, ALUCtrl  output  2 each  extend select; register address selects; ALU op: 00=ADD, 01=SUB, 10=AND, 11=ORR.
REQ-013 State  output  4  current FSM state, for debug.

Function
REQ-014 FSM states and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; encodings 10-15 SHALL go to FETCH.
REQ-015 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUCtrl=00, ResultSrc=10, IRWrite=1, PCWrite=1; next state DECODE.
REQ-016 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; next state: Op=01 -> MEMADR; Op=00 and Funct[5]=0 -> EXECUTER; Op=00 and Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH, with no write enables asserted.
REQ-017 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUCtrl=00; next state MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-018 MEMREAD: AdrSrc=1, ResultSrc=00; next state MEMWB.
REQ-019 MEMWB: ResultSrc=01, register write (per REQ-026); next state FETCH.
REQ-020 MEMWRITE: AdrSrc=1, MemWrite=CondExR; next state FETCH.
REQ-021 EXECUTER / EXECUTEI: ALUSrcA=0; ALUSrcB=00 (EXECUTER) or 01 (EXECUTEI); ALUCtrl from Funct[4:1]; next state ALUWB.
REQ-022 ALUWB: ResultSrc=00, register write (per REQ-026); next state FETCH.
REQ-023 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUCtrl=00, ResultSrc=10, PCWrite=CondExR; next state FETCH.
REQ-024 ALU decode: Funct[4:1]=0100 -> 00, 0010 -> 01, 0000 -> 10, 1100 -> 11; any other command -> ALUCtrl=00, no RegWrite and no flag write.
REQ-025 Combinational decode in every state: ImmSrc=Op; RegSrc[0]=(Op=10); RegSrc[1]=(Op=01 and Funct[0]=0).
REQ-026 Register write in ALUWB/MEMWB: if CondExR=1 and Rd=1111 -> PCWrite=1 and RegWrite=0; if CondExR=1 and Rd!=1111 -> RegWrite=1; if CondExR=0 -> neither asserted.
REQ-027 Condition codes evaluated on stored flags: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 -> 0.
REQ-028 CondExR SHALL be registered at the clock edge that ends DECODE and held until the next DECODE.
REQ-029 Stored flags: at the edge ending EXECUTER/EXECUTEI, if CondExR=1 and S=Funct[0]=1 and the command is valid, N and Z SHALL load from ALUFlags; C and V SHALL load only for ADD/SUB.
REQ-030 A flag update SHALL NOT alter CondExR for the current instruction.
REQ-031 Cycle counts: branch 3; data-processing 4; STR 4; LDR 5; Op=11 2.

Reset
REQ-032 Reset low SHALL asynchronously set State=FETCH, flags=0000, CondExR=0.
REQ-033 While Reset is low, PCWrite/IRWrite/RegWrite/MemWrite SHALL be 0; other outputs SHALL hold FETCH values.
REQ-034 After Reset rises, the first rising edge SHALL perform a FETCH; a reset asserted mid-instruction SHALL abort it with no further writes.

Structure
REQ-035 Package ctrl_pkg SHALL hold state encodings, ALUCtrl codes, ALUSrcB/ResultSrc codes and condition-code constants.
REQ-036 Sub-module cond_unit SHALL contain the flag register, condition evaluation and CondExR register; FSM and decoders stay in the top.

Verification
REQ-037 Reset low during MEMREAD -> State=0, all write enables 0; after release, cycle 1: IRWrite=1, PCWrite=1.
REQ-038 ADDS Cond=1110 Op=00 Funct=001001 Rd=0001, ALUFlags=0100 in EXECUTER -> states 0,1,6,8; RegWrite=1 only in ALUWB; stored Z=1.
REQ-039 Op=10 Cond=0000: Z=1 -> BRANCH PCWrite=1, RegSrc=01, ImmSrc=10; Z=0 -> PCWrite=0; 3 cycles each.
REQ-040 LDR Op=01 Funct=011001 -> states 0,1,2,3,4; with Rd=0010, RegWrite=1 in MEMWB; with Rd=1111, PCWrite=1, RegWrite=0.
REQ-041 STR Funct=011000 Cond=0001 with Z=1 -> MEMWRITE with MemWrite=0, RegSrc=10, AdrSrc=1.
REQ-042 SUBS Cond=0000 with Z=1 and ALUFlags=0000 -> flags cleared after EXECUTER; RegWrite=1 in ALUWB (CondExR held 1).

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle ARM controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - stored NZCV flags, condition check and latched CondExR
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       cond_load,
  input  logic       nz_we,
  input  logic       cv_we,
  output logic       cond_ex
);

  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;
  logic       cond_met;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags_q;

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      COND_EQ: cond_met = z;
      COND_NE: cond_met = !z;
      COND_CS: cond_met = c;
      COND_CC: cond_met = !c;
      COND_MI: cond_met = n;
      COND_PL: cond_met = !n;
      COND_VS: cond_met = v;
      COND_VC: cond_met = !v;
      COND_HI: cond_met = c & !z;
      COND_LS: cond_met = !c | z;
      COND_GE: cond_met = (n == v);
      COND_LT: cond_met = (n != v);
      COND_GT: cond_met = !z & (n == v);
      COND_LE: cond_met = z | (n != v);
      COND_AL: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // CondExR only reloads in DECODE, so a flag write never disturbs the current instruction
  always_comb begin
    flags_d = flags_q;
    if (nz_we) flags_d[3:2] = alu_flags[3:2];
    if (cv_we) flags_d[1:0] = alu_flags[1:0];
    cond_ex_d = cond_load ? cond_met : cond_ex_q;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  assign cond_ex = cond_ex_q;

endmodule

// File: rtl/arm_multicycle_controller.sv
// rtl/arm_multicycle_controller.sv - multicycle ARM control FSM and decoders
module arm_multicycle_controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       Reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUCtrl,
  output logic [3:0] State
);

  state_t     state_q, state_d;
  logic       cond_ex;
  logic       cmd_valid, cmd_arith;
  logic [1:0] alu_dp;
  logic       in_exec, nz_we, cv_we;
  logic       pc_w, ir_w, reg_w, mem_w;

  always_comb begin
    cmd_valid = 1'b1;
    cmd_arith = 1'b0;
    alu_dp    = ALU_ADD;
    case (Funct[4:1])
      CMD_ADD: begin alu_dp = ALU_ADD; cmd_arith = 1'b1; end
      CMD_SUB: begin alu_dp = ALU_SUB; cmd_arith = 1'b1; end
      CMD_AND: alu_dp = ALU_AND;
      CMD_ORR: alu_dp = ALU_ORR;
      default: cmd_valid = 1'b0;
    endcase
  end

  assign in_exec = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI);
  assign nz_we   = in_exec & cond_ex & Funct[0] & cmd_valid;
  assign cv_we   = nz_we & cmd_arith;

  cond_unit u_cond (
    .clk       (clk),
    .Reset     (Reset),
    .cond      (Cond),
    .alu_flags (ALUFlags),
    .cond_load (state_q == S_DECODE),
    .nz_we     (nz_we),
    .cv_we     (cv_we),
    .cond_ex   (cond_ex)
  );

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_w      = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RD2;
    ResultSrc = RES_ALUOUT;
    ALUCtrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_w      = 1'b1;
        pc_w      = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        pc_w      = cond_ex & (Rd == 4'hF);
        reg_w     = cond_ex & (Rd != 4'hF);
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = cond_ex;
      end
      S_EXECUTER: ALUCtrl = alu_dp;
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUCtrl = alu_dp;
      end
      // Unrecognised commands complete the cycle count but write nothing
      S_ALUWB: begin
        pc_w  = cond_ex & cmd_valid & (Rd == 4'hF);
        reg_w = cond_ex & cmd_valid & (Rd != 4'hF);
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_w      = cond_ex;
      end
      default: ;
    endcase
  end

  // Reset is asynchronous, so write enables are masked combinationally while it is low
  assign PCWrite  = pc_w & Reset;
  assign IRWrite  = ir_w & Reset;
  assign RegWrite = reg_w & Reset;
  assign MemWrite = mem_w & Reset;

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01) & ~Funct[0], (Op == 2'b10)};
  assign State  = state_q;

endmodule
